mac_result_fifo: RTL

Result buffer directly downstream of the MAC stage. It captures every 20-bit signed accumulator value on the cycle the MAC flags it valid, and stores results in a DEPTH-entry first-word-fall-through FIFO. Results are presented to the consumer over a valid/ready handshake. Because the MAC has no backpressure input, the block drives an `almost_full` flag that the upstream driver uses to gate `valid_in`, sized for the MAC's 2-cycle valid_in→valid_out latency.

---
 rtl/mac_result_fifo.sv | 81 ++++++++
 1 files changed

// File: rtl/mac_result_fifo.sv
// Result buffer behind the MAC: captures each accumulator value on in_valid and
// hands it to the consumer through a first-word-fall-through FIFO.
module mac_result_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     almost_full,
   output logic                     overflow,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(DEPTH - 2);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             push, pop;

   // Handshake: the head transfers on any cycle where out_valid && out_ready;
   // out_valid never depends on out_ready, and in_valid has no ready (the
   // upstream throttles itself with almost_full instead).
   always_comb begin
      pop        = out_valid && out_ready;
      push       = in_valid && ((count_q < FULL_C) || pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (in_valid & ~push);
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately left out of reset; only occupancy qualifies it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign out_data    = mem_q[rd_ptr_q];
   assign out_valid   = (count_q != '0);
   assign almost_full = (count_q >= AF_C);
   assign overflow    = overflow_q;
   assign count       = count_q;

endmodule
